// File: rtl/mandelbrot_frame_sched.sv
// Frame sequencer for the mandelbrot pixel engine: issues one core run per
// pixel, collects iteration counts into a credit-tracked output FIFO with
// frame/line markers, and applies optional zoom/pan between frames.

package mandelbrot_frame_sched_pkg;

  // One output FIFO entry: iteration count plus position markers
  typedef struct packed {
    logic [3:0] ctr;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_entry_t;

endpackage

module mandelbrot_frame_sched
  import mandelbrot_frame_sched_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 10,
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                enable,
  input  logic                auto_zoom,
  input  logic [2:0]          zoom_step,
  input  logic [BITWIDTH-1:0] pan_cr,
  input  logic [BITWIDTH-1:0] pan_ci,
  input  logic [6:0]          init_scaling,
  input  logic [BITWIDTH-1:0] init_cr,
  input  logic [BITWIDTH-1:0] init_ci,
  output logic                core_run,
  input  logic                core_running,
  input  logic                core_finished,
  input  logic [3:0]          core_ctr,
  output logic [6:0]          core_scaling,
  output logic [BITWIDTH-1:0] core_cr_offset,
  output logic [BITWIDTH-1:0] core_ci_offset,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_data,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_eof,
  output logic                busy,
  output logic [7:0]          frame_count,
  output logic                sync_err
);

  localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned HALF_W = WIDTH / 2;
  localparam int unsigned HALF_H = HEIGHT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_COMPUTE,
    S_FRAME_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                inflight_q, inflight_d;
  logic                run_d;
  logic [6:0]          scaling_d;
  logic [BITWIDTH-1:0] cr_d, ci_d;
  logic [7:0]          frame_count_d;
  logic                sync_err_d;
  logic                busy_d;

  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  pix_entry_t          mem [FIFO_DEPTH];
  pix_entry_t          head_c;
  pix_entry_t          push_entry_c;

  logic                eol_c, sof_c, last_px_c;
  logic                push_c, pop_c, credit_ok_c;
  logic [6:0]          zoom_d_c;
  logic [BITWIDTH-1:0] cr_step_c, ci_step_c;

  // Position decode of the pixel currently being computed
  assign eol_c     = (x_q == XW'(WIDTH - 1));
  assign sof_c     = (x_q == '0) && (y_q == '0);
  assign last_px_c = eol_c && (y_q == YW'(HEIGHT - 1));

  // A pixel completes once the core drops running after our run pulse
  assign push_c       = (state_q == S_COMPUTE) && !core_run && !core_running;
  assign pop_c        = pix_valid && pix_ready;
  assign credit_ok_c  = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign push_entry_c = '{ctr: core_ctr, sof: sof_c, eol: eol_c, eof: last_px_c};

  // Zoom step saturates so scaling never goes below zero
  assign zoom_d_c  = (7'(zoom_step) < core_scaling) ? 7'(zoom_step) : core_scaling;
  assign cr_step_c = BITWIDTH'(HALF_W * 32'(zoom_d_c));
  assign ci_step_c = BITWIDTH'(HALF_H * 32'(zoom_d_c));

  // Next-state and next-register logic for the frame sequencer
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    inflight_d    = inflight_q;
    run_d         = 1'b0;
    scaling_d     = core_scaling;
    cr_d          = core_cr_offset;
    ci_d          = core_ci_offset;
    frame_count_d = frame_count;
    sync_err_d    = sync_err;

    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_LOAD;
      end

      S_LOAD: begin
        scaling_d  = init_scaling;
        cr_d       = init_cr;
        ci_d       = init_ci;
        x_d        = '0;
        y_d        = '0;
        inflight_d = 1'b0;
        sync_err_d = 1'b0;
        state_d    = S_ISSUE;
      end

      S_ISSUE: begin
        if (credit_ok_c && !core_running) begin
          run_d      = 1'b1;
          inflight_d = 1'b1;
          state_d    = S_COMPUTE;
        end
      end

      S_COMPUTE: begin
        if (push_c) begin
          inflight_d = 1'b0;
          if (last_px_c) begin
            if (!core_finished) sync_err_d = 1'b1;
            state_d = S_FRAME_DONE;
          end else begin
            if (core_finished) sync_err_d = 1'b1;
            if (eol_c) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            state_d = S_ISSUE;
          end
        end
      end

      S_FRAME_DONE: begin
        frame_count_d = frame_count + 8'd1;
        if (auto_zoom) begin
          scaling_d = core_scaling - zoom_d_c;
          cr_d      = core_cr_offset + cr_step_c + pan_cr;
          ci_d      = core_ci_offset + ci_step_c + pan_ci;
        end
        x_d     = '0;
        y_d     = '0;
        state_d = enable ? S_ISSUE : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state and registered core/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      inflight_q     <= 1'b0;
      core_run       <= 1'b0;
      core_scaling   <= '0;
      core_cr_offset <= '0;
      core_ci_offset <= '0;
      frame_count    <= '0;
      sync_err       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      inflight_q     <= inflight_d;
      core_run       <= run_d;
      core_scaling   <= scaling_d;
      core_cr_offset <= cr_d;
      core_ci_offset <= ci_d;
      frame_count    <= frame_count_d;
      sync_err       <= sync_err_d;
      busy           <= busy_d;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= push_entry_c;
  end

  // Head of FIFO drives the sink; fields read zero while empty
  assign head_c    = mem[rd_ptr_q];
  assign pix_valid = (count_q != '0);
  assign pix_data  = pix_valid ? head_c.ctr : 4'd0;
  assign pix_sof   = pix_valid ? head_c.sof : 1'b0;
  assign pix_eol   = pix_valid ? head_c.eol : 1'b0;
  assign pix_eof   = pix_valid ? head_c.eof : 1'b0;

endmodule

// File: tb/tb_mandelbrot_frame_sched.sv
// Self-checking bench for mandelbrot_frame_sched on a small 4x2 frame with a
// behavioural core (fixed latency, ctr = x + y) and a scoreboarded pixel sink.

module tb_mandelbrot_frame_sched;

  localparam int unsigned BW   = 10;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned D    = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned LAT  = 5;

  logic          clk;
  logic          rst;
  logic          frame_start, enable, auto_zoom;
  logic [2:0]    zoom_step;
  logic [BW-1:0] pan_cr, pan_ci, init_cr, init_ci;
  logic [6:0]    init_scaling;
  logic          core_run, core_running, core_finished;
  logic [3:0]    core_ctr;
  logic [6:0]    core_scaling;
  logic [BW-1:0] core_cr_offset, core_ci_offset;
  logic          pix_valid, pix_ready, pix_sof, pix_eol, pix_eof;
  logic [3:0]    pix_data;
  logic          busy, sync_err;
  logic [7:0]    frame_count;

  mandelbrot_frame_sched #(
    .BITWIDTH(BW), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .auto_zoom(auto_zoom), .zoom_step(zoom_step), .pan_cr(pan_cr), .pan_ci(pan_ci),
    .init_scaling(init_scaling), .init_cr(init_cr), .init_ci(init_ci),
    .core_run(core_run), .core_running(core_running), .core_finished(core_finished),
    .core_ctr(core_ctr), .core_scaling(core_scaling), .core_cr_offset(core_cr_offset),
    .core_ci_offset(core_ci_offset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .frame_count(frame_count), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected sink record for pixel n of a frame: {ctr, sof, eol, eof}
  function automatic logic [6:0] exp_pix(input int n);
    int x, y;
    x = n % W;
    y = n / W;
    return {4'(x + y), n == 0, x == W - 1, n == NPIX - 1};
  endfunction

  // Reference for the between-frame zoom/pan update, straight from the formula
  function automatic logic [26:0] zoom_model(input logic az, input int step, input int pcr,
                                            input int pci, input int s, input int cr, input int ci);
    int d, ns, ncr, nci;
    if (!az) return {7'(s), 10'(cr), 10'(ci)};
    d   = (step < s) ? step : s;
    ns  = s - d;
    ncr = (cr + (W / 2) * d + pcr) % 1024;
    nci = (ci + (H / 2) * d + pci) % 1024;
    return {7'(ns), 10'(ncr), 10'(nci)};
  endfunction

  // Behavioural core: busy LAT cycles after a run, then reports x+y of its own pixel index
  int core_n;
  int core_cnt;
  int fin_mode;  // 0 finished on last pixel, 1 also early on pixel 5, 2 never
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_running  <= 1'b0;
      core_finished <= 1'b0;
      core_ctr      <= 4'd0;
      core_cnt      <= 0;
      core_n        <= 0;
    end else if (core_run && !core_running) begin
      core_running  <= 1'b1;
      core_finished <= 1'b0;
      core_cnt      <= LAT - 1;
    end else if (core_running) begin
      if (core_cnt == 0) begin
        core_running  <= 1'b0;
        core_ctr      <= 4'((core_n % W) + (core_n / W));
        core_finished <= (fin_mode != 2 && core_n == NPIX - 1) || (fin_mode == 1 && core_n == 4);
        core_n        <= (core_n + 1) % NPIX;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Sink ready driver: fixed level or random
  logic rnd_ready, ready_val;
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : ready_val;
    end
  end

  // Monitor: run-pulse protocol, offset stability mid-pixel, and pixel scoreboard
  int sb_n = 0;
  int sb_total = 0;
  int run_count = 0;
  logic [26:0] run_offs;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_n = 0;
      end else begin
        if (core_run) begin
          run_count++;
          check("run_while_core_busy", 32'(core_running), 0);
          run_offs = {core_scaling, core_cr_offset, core_ci_offset};
        end
        if (core_running)
          check("offsets_stable_mid_pixel", 32'({core_scaling, core_cr_offset, core_ci_offset}),
                32'(run_offs));
        if (pix_valid && pix_ready) begin
          check($sformatf("pix[%0d]{ctr,sof,eol,eof}", sb_n),
                32'({pix_data, pix_sof, pix_eol, pix_eof}), 32'(exp_pix(sb_n)));
          sb_n = (sb_n + 1) % NPIX;
          sb_total++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic az, input logic [2:0] st, input logic [9:0] pcr,
                         input logic [9:0] pci, input logic [6:0] s, input logic [9:0] cr,
                         input logic [9:0] ci);
    auto_zoom = az; zoom_step = st; pan_cr = pcr; pan_ci = pci;
    init_scaling = s; init_cr = cr; init_ci = ci;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_timeout(busy)", 32'(busy), 0);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (pix_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout(pix_valid)", 32'(pix_valid), 0);
  endtask

  task automatic wait_frame(input int budget);
    logic [7:0] fc0;
    int k = 0;
    fc0 = frame_count;
    @(negedge clk);
    while (frame_count == fc0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_frame_timeout", 32'(frame_count != fc0), 1);
  endtask

  typedef struct {
    logic       az;
    logic [2:0] step;
    logic [9:0] pcr, pci;
    logic [6:0] s;
    logic [9:0] cr, ci;
    logic [6:0] es;
    logic [9:0] ecr, eci;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] exp_frames;
  int         tot0;

  initial begin
    // Zoom/pan vectors with hand-derived results (W/2 = 2, H/2 = 1)
    tbl[0] = '{1'b0, 3'd3, 10'h005, 10'h005, 7'd10,  10'h100, 10'h050, 7'd10, 10'h100, 10'h050};
    tbl[1] = '{1'b1, 3'd3, 10'h000, 10'h000, 7'd2,   10'h100, 10'h050, 7'd0,  10'h104, 10'h052};
    tbl[2] = '{1'b1, 3'd3, 10'h000, 10'h000, 7'd0,   10'h104, 10'h052, 7'd0,  10'h104, 10'h052};
    tbl[3] = '{1'b1, 3'd0, 10'h3FF, 10'h000, 7'd5,   10'h000, 10'h000, 7'd5,  10'h3FF, 10'h000};
    tbl[4] = '{1'b1, 3'd7, 10'h001, 10'h002, 7'd100, 10'h3FC, 10'h3FF, 7'd93, 10'h00B, 10'h008};
    tbl[5] = '{1'b1, 3'd4, 10'h3F0, 10'h3FE, 7'd3,   10'h200, 10'h010, 7'd0,  10'h1F6, 10'h011};

    rst = 1'b1; frame_start = 1'b0; enable = 1'b0; fin_mode = 0;
    rnd_ready = 1'b0; ready_val = 1'b1; exp_frames = 8'd0;
    set_cfg(1'b0, 3'd0, 10'h0, 10'h0, 7'd0, 10'h0, 10'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs{run,valid,busy,sync}", 32'({core_run, pix_valid, busy, sync_err}), 0);
    check("reset_frame_count", 32'(frame_count), 0);
    check("reset_offsets", 32'({core_scaling, core_cr_offset, core_ci_offset}), 0);
    check("reset_pix_fields", 32'({pix_data, pix_sof, pix_eol, pix_eof}), 0);
    #2 rst = 1'b0;

    // Basic frame, sink always ready
    set_cfg(1'b0, 3'd0, 10'h0, 10'h0, 7'd8, 10'h100, 10'h000);
    run_count = 0; tot0 = sb_total;
    start_frame();
    wait_idle(400);
    exp_frames++;
    check("basic_run_count", 32'(run_count), NPIX);
    check("basic_pixels_out", 32'(sb_total - tot0), NPIX);
    check("basic_frame_count", 32'(frame_count), 32'(exp_frames));
    check("basic_sync_err", 32'(sync_err), 0);
    check("basic_cr_offset", 32'(core_cr_offset), 'h100);
    check("basic_fifo_empty", 32'(pix_valid), 0);

    // Backpressure: credits stop issue at FIFO_DEPTH; frame_start while busy is ignored
    ready_val = 1'b0; run_count = 0; tot0 = sb_total;
    @(posedge clk); #1;
    start_frame();
    repeat (120) @(negedge clk);
    check("bp_run_count_stalled", 32'(run_count), D);
    check("bp_head{valid,sof,data}", 32'({pix_valid, pix_sof, pix_data}), 32'({1'b1, 1'b1, 4'd0}));
    start_frame();
    repeat (20) @(negedge clk);
    check("bp_run_count_after_ignored_start", 32'(run_count), D);
    ready_val = 1'b1;
    wait_idle(600);
    drain(20);
    exp_frames++;
    check("bp_run_count_total", 32'(run_count), NPIX);
    check("bp_pixels_out", 32'(sb_total - tot0), NPIX);

    // Table-driven zoom/pan vectors, one frame each
    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i].az, tbl[i].step, tbl[i].pcr, tbl[i].pci, tbl[i].s, tbl[i].cr, tbl[i].ci);
      start_frame();
      wait_idle(400);
      exp_frames++;
      check($sformatf("tbl%0d_scaling", i), 32'(core_scaling), 32'(tbl[i].es));
      check($sformatf("tbl%0d_cr", i), 32'(core_cr_offset), 32'(tbl[i].ecr));
      check($sformatf("tbl%0d_ci", i), 32'(core_ci_offset), 32'(tbl[i].eci));
      check($sformatf("tbl%0d_frame_count", i), 32'(frame_count), 32'(exp_frames));
    end

    // Auto-zoom across back-to-back frames: saturate to 0, then hold
    set_cfg(1'b1, 3'd3, 10'h000, 10'h000, 7'd2, 10'h100, 10'h050);
    enable = 1'b1;
    start_frame();
    wait_frame(400);
    exp_frames++;
    check("chainA_f1_offsets", 32'({core_scaling, core_cr_offset, core_ci_offset}),
          32'({7'd0, 10'h104, 10'h052}));
    check("chainA_f1_busy", 32'(busy), 1);
    enable = 1'b0;
    wait_frame(400);
    exp_frames++;
    check("chainA_f2_offsets", 32'({core_scaling, core_cr_offset, core_ci_offset}),
          32'({7'd0, 10'h104, 10'h052}));
    wait_idle(50);
    check("chainA_frame_count", 32'(frame_count), 32'(exp_frames));

    // Pan of -1 per frame wraps cr through zero
    set_cfg(1'b1, 3'd0, 10'h3FF, 10'h000, 7'd9, 10'h001, 10'h020);
    enable = 1'b1;
    start_frame();
    wait_frame(400);
    check("chainB_cr_f1", 32'(core_cr_offset), 'h000);
    wait_frame(400);
    check("chainB_cr_f2", 32'(core_cr_offset), 'h3FF);
    enable = 1'b0;
    wait_frame(400);
    check("chainB_cr_f3", 32'(core_cr_offset), 'h3FE);
    check("chainB_scaling_ci", 32'({core_scaling, core_ci_offset}), 32'({7'd9, 10'h020}));
    wait_idle(50);
    exp_frames += 8'd3;
    check("chainB_frame_count", 32'(frame_count), 32'(exp_frames));

    // Random configurations with a random-ready sink, checked against the model
    rnd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [26:0] expv;
      set_cfg(1'($urandom), 3'($urandom), 10'($urandom), 10'($urandom),
              7'($urandom), 10'($urandom), 10'($urandom));
      expv = zoom_model(auto_zoom, int'(zoom_step), int'(pan_cr), int'(pan_ci),
                        int'(init_scaling), int'(init_cr), int'(init_ci));
      tot0 = sb_total;
      start_frame();
      wait_idle(2000);
      drain(200);
      exp_frames++;
      check($sformatf("rnd%0d_offsets", i),
            32'({core_scaling, core_cr_offset, core_ci_offset}), 32'(expv));
      check($sformatf("rnd%0d_pixels_out", i), 32'(sb_total - tot0), NPIX);
    end
    rnd_ready = 1'b0;
    ready_val = 1'b1;

    // Early core_finished sets sync_err, held until the next LOAD
    fin_mode = 1;
    set_cfg(1'b0, 3'd0, 10'h0, 10'h0, 7'd1, 10'h010, 10'h020);
    start_frame();
    wait_idle(400);
    exp_frames++;
    fin_mode = 0;
    check("sync_early_set", 32'(sync_err), 1);
    repeat (5) @(negedge clk);
    check("sync_sticky_idle", 32'(sync_err), 1);
    start_frame();
    @(negedge clk);
    check("sync_held_in_load", 32'(sync_err), 1);
    wait_idle(400);
    exp_frames++;
    check("sync_cleared_clean_frame", 32'(sync_err), 0);

    // Missing core_finished on the last pixel also flags sync_err
    fin_mode = 2;
    start_frame();
    wait_idle(400);
    exp_frames++;
    fin_mode = 0;
    check("sync_missing_finish", 32'(sync_err), 1);
    check("sync_frame_count", 32'(frame_count), 32'(exp_frames));

    // Asynchronous reset mid-frame with two entries queued
    ready_val = 1'b0; run_count = 0;
    set_cfg(1'b0, 3'd0, 10'h0, 10'h0, 7'd5, 10'h155, 10'h0AA);
    @(posedge clk); #1;
    start_frame();
    begin
      int k = 0;
      while (run_count < 3 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("mid_rst_third_run_issued", 32'(run_count), 3);
    check("mid_rst_fifo_nonempty", 32'(pix_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_async{valid,busy,run,sync}", 32'({pix_valid, busy, core_run, sync_err}), 0);
    check("mid_rst_async_frame_count", 32'(frame_count), 0);
    check("mid_rst_async_offsets", 32'({core_scaling, core_cr_offset, core_ci_offset}), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    exp_frames = 8'd0;
    ready_val = 1'b1; run_count = 0; tot0 = sb_total;
    start_frame();
    wait_idle(400);
    exp_frames++;
    check("post_rst_run_count", 32'(run_count), NPIX);
    check("post_rst_pixels_out", 32'(sb_total - tot0), NPIX);
    check("post_rst_frame_count", 32'(frame_count), 32'(exp_frames));
    check("post_rst_cr_offset", 32'(core_cr_offset), 'h155);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
